// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID latch.
// Owns the fetch PC, keeps at most one instruction-memory request in flight,
// buffers one fetched instruction and drives NOP bubbles when the buffer is empty.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request outstanding; may issue when buffer is free or draining
// WAIT  | request outstanding, result wanted
// KILL  | stale request outstanding after a redirect; result is discarded
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ir_out,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] pc_buf_q, pc_buf_d;
    logic [31:0] ir_buf_q, ir_buf_d;
    logic        buf_valid_q, buf_valid_d;

    logic advance;
    logic redir;
    logic issue;
    logic req_raw;

    assign advance = en & ~stall;
    assign redir   = en & redirect;
    // A new fetch may only start when the buffer has room at the next edge,
    // which is why an arriving ack can never overflow the buffer.
    assign issue   = (~buf_valid_q | advance) & ~redir;

    // Request is combinational; a reset abandons any transaction immediately.
    always_comb begin
        req_raw = 1'b0;
        unique case (state_q)
            S_IDLE:  req_raw = issue;
            S_WAIT:  req_raw = 1'b1;
            S_KILL:  req_raw = 1'b1;
            default: req_raw = 1'b0;
        endcase
    end

    assign imem_req  = req_raw & ~rst;
    assign imem_addr = req_addr_q;

    assign pc_out   = pc_buf_q;
    assign ir_out   = buf_valid_q ? ir_buf_q : NOP_INSTR;
    assign if_valid = buf_valid_q;

    // Next-state logic: redirect beats ack/load, which beats the advance drain.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        redir_pc_d  = redir_pc_q;
        pc_buf_d    = pc_buf_q;
        ir_buf_d    = ir_buf_q;
        buf_valid_d = buf_valid_q & ~advance;

        unique case (state_q)
            S_IDLE: begin
                if (redir) begin
                    buf_valid_d = 1'b0;
                    req_addr_d  = redirect_pc;
                end else if (issue && imem_ack) begin
                    pc_buf_d    = req_addr_q;
                    ir_buf_d    = imem_rdata;
                    buf_valid_d = 1'b1;
                    req_addr_d  = req_addr_q + 32'd4;
                end else if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack && !redir) begin
                    pc_buf_d    = req_addr_q;
                    ir_buf_d    = imem_rdata;
                    buf_valid_d = 1'b1;
                    req_addr_d  = req_addr_q + 32'd4;
                    state_d     = S_IDLE;
                end else if (imem_ack && redir) begin
                    buf_valid_d = 1'b0;
                    req_addr_d  = redirect_pc;
                    state_d     = S_IDLE;
                end else if (redir) begin
                    buf_valid_d = 1'b0;
                    redir_pc_d  = redirect_pc;
                    state_d     = S_KILL;
                end
            end
            S_KILL: begin
                // The old address stays on the bus until memory answers.
                buf_valid_d = 1'b0;
                if (redir) begin
                    redir_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    req_addr_d = redir ? redirect_pc : redir_pc_q;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and buffer registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_addr_q  <= RESET_PC;
            redir_pc_q  <= 32'd0;
            pc_buf_q    <= 32'd0;
            ir_buf_q    <= 32'd0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            redir_pc_q  <= redir_pc_d;
            pc_buf_q    <= pc_buf_d;
            ir_buf_q    <= ir_buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline latch. It owns the fetch PC and runs a one-outstanding-request handshake with instruction memory. It buffers one fetched instruction and presents `pc_out`/`ir_out` to the IF/ID latch. It absorbs pipeline stalls and control-flow redirects, and emits NOP bubbles (`32'h00000013`) whenever no valid instruction is available.

## Interface
- `RESET_PC`, default `32'h00000000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h00000013`: bubble encoding driven on `ir_out` when the buffer is empty.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `en`  in  1  pipeline enable, same signal that drives the IF/ID latch `EN`.
- `stall`  in  1  data-hazard stall, same signal as the IF/ID `Data_stall`.
- `redirect`  in  1  taken branch/jump; flush the fetch stream.
- `redirect_pc`  in  32  redirect target, word aligned.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  request address.
- `imem_ack`  in  1  request complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `pc_out`  out  32  PC of the buffered instruction, to IF/ID `PC_in`.
- `ir_out`  out  32  buffered instruction or `NOP_INSTR`, to IF/ID `IR_in`.
- `if_valid`  out  1  buffer holds a real instruction.

## Operation
- Internal signals: `advance = en & ~stall`; `redir = en & redirect`. `redirect` is ignored when `en` = 0.
- Internal registers:
  - `req_addr`: next address to fetch.
  - `redir_pc`: pending redirect target.
  - `pc_buf`, `ir_buf`, `buf_valid`: the one-entry instruction buffer.
  - `state`: one of IDLE, WAIT, KILL.
- Output mapping: `pc_out = pc_buf`; `ir_out = buf_valid ? ir_buf : NOP_INSTR`; `if_valid = buf_valid`.
- Buffer drain: if `advance` and no load happens this cycle, `buf_valid` <= 0.
- IDLE (no request outstanding):
  - `issue = (~buf_valid | advance) & ~redir`; `imem_req = issue`; `imem_addr = req_addr`.
  - On `redir`: `buf_valid` <= 0, `req_addr` <= `redirect_pc`, stay IDLE.
  - On `issue & imem_ack`: load the buffer (`pc_buf` <= `req_addr`, `ir_buf` <= `imem_rdata`, `buf_valid` <= 1), `req_addr` += 4, stay IDLE.
  - On `issue & ~imem_ack`: go to WAIT.
- WAIT (request outstanding):
  - `imem_req` = 1 and `imem_addr = req_addr`, both held stable until ack.
  - On `imem_ack & ~redir`: load the buffer as above, `req_addr` += 4, go to IDLE.
  - On `imem_ack & redir`: discard the data, `buf_valid` <= 0, `req_addr` <= `redirect_pc`, go to IDLE.
  - On `~imem_ack & redir`: `buf_valid` <= 0, `redir_pc` <= `redirect_pc`, go to KILL.
- KILL (stale request still outstanding):
  - `imem_req` = 1 and `imem_addr = req_addr` (the old address); `buf_valid` stays 0.
  - On a further `redir`: `redir_pc` <= `redirect_pc` (latest target wins).
  - On `imem_ack`: discard the data; `req_addr` <= `redir` ? `redirect_pc` : `redir_pc`; go to IDLE.
- Buffer capacity: the buffer is always free or draining when an ack arrives, because a request is only issued when `~buf_valid | advance`. No overflow path exists.
- Priority: `rst` > `redir` > ack/load > `advance` drain.
- Arithmetic: `req_addr` += 4 is modulo 2^32; `32'hFFFFFFFC` wraps to `0`.

## Timing
- Reset values:
  - State: `state` = IDLE, `req_addr` = `RESET_PC`, `redir_pc` = 0, `pc_buf` = 0, `buf_valid` = 0.
  - Outputs: `ir_out` = `NOP_INSTR`, `if_valid` = 0, `pc_out` = 0. `imem_req` is forced 0 while `rst` is high.
  - Reset mid-request abandons the transaction. Memory must tolerate the dropped request.
- `imem_req` is combinational from the state and buffer; all other outputs are registered.
- Latency: with zero-wait memory (ack in the request cycle), the instruction at `RESET_PC` appears on `ir_out` the cycle after reset release. Sustained throughput is 1 instruction/cycle while `advance` = 1.
- With N wait cycles, each instruction takes N+1 cycles, and `ir_out` = NOP in between.
- Redirect is visible on `ir_out` (NOP) the next cycle. The target's instruction appears no earlier than 2 cycles after `redir` with zero-wait memory, plus the remaining wait of any killed request.
- `stall` or `en` = 0 with a full buffer: the buffer holds, and no new request is issued from IDLE. An outstanding WAIT request still completes.

## Test plan
- Reset release, zero-wait memory returning `addr+0x100`, `advance` = 1 throughout:
  - `imem_addr` = 0, 4, 8 on consecutive cycles.
  - `pc_out`/`ir_out` = 0/0x100, 4/0x104, 8/0x108 one cycle later each.
- Memory with 2 wait cycles:
  - Each `imem_addr` is held for 3 cycles with `imem_req` = 1.
  - `ir_out` = `32'h00000013`, `if_valid` = 0 between instructions.
- `stall` = 1 for 3 cycles with the buffer full at PC 0x8:
  - `pc_out`/`ir_out` hold at PC 0x8, `imem_req` = 0.
  - After release, PC 0xC follows on the next cycle.
- Redirect to 0x40 while a request for 0x10 is in WAIT (ack 2 cycles later):
  - State goes to KILL, the 0x10 data is dropped, and `ir_out` = NOP.
  - The next `imem_addr` is 0x40, and PC 0x40 reaches `pc_out`.
- Two redirects during KILL (0x40 then 0x80): the fetch resumes at 0x80.
- `req_addr` = `32'hFFFFFFFC` with zero-wait memory: the next request is 0x0. Assert `rst` mid-WAIT: `imem_req` drops to 0 immediately, and fetch restarts at `RESET_PC` after release.
